rle_encoder: RTL

Run-length encoder producing the 16-bit `{run[9:0], colour[5:0]}` word stream consumed by the VGA RLE video decoder. It accepts one 6-bit pixel per cycle under a valid/ready handshake, merges identical consecutive pixels into runs, and buffers the encoded words in a small output FIFO for the flash/PSRAM writer. It is the write-side counterpart of the playback path and produces stream images for on-chip capture and for test.

---
 rtl/rle_encoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rle_encoder.sv
// Run-length encoder: folds identical consecutive RGB222 pixels into {run, colour}
// words and queues them in a small FIFO that accepts up to two words per cycle.
module rle_encoder #(
  parameter int MAX_RUN    = 991,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic [5:0]  pixel_colour,
  input  logic        pixel_last,
  input  logic        finish,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_data,
  output logic        done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int READY_LIM_I = FIFO_DEPTH - 2;
  localparam logic [CW-1:0] READY_LIM  = READY_LIM_I[CW-1:0];
  localparam logic [CW-1:0] FIFO_FULL  = FIFO_DEPTH[CW-1:0];
  localparam logic [9:0]    MAX_RUN_W  = MAX_RUN[9:0];
  localparam logic [15:0]   STOP_WORD  = 16'hFFC0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [5:0]      r_colour;
  logic [9:0]      r_cnt;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_done;

  state_t          w_state_nxt;
  logic [5:0]      w_colour_nxt;
  logic [9:0]      w_cnt_nxt;
  logic [9:0]      w_cnt_inc;
  logic            w_acc;
  logic            w_full;
  logic            w_pop;
  logic            w_push0;
  logic            w_push1;
  logic [15:0]     w_word0;
  logic [15:0]     w_word1;
  logic [CW-1:0]   w_count_nxt;

  // The registered count is used on purpose: a same-cycle pop earns no credit.
  assign pixel_ready = (r_state != S_DONE) && !finish && (r_count <= READY_LIM);
  assign w_acc       = pixel_valid && pixel_ready;
  assign w_full      = (r_count == FIFO_FULL);
  assign w_pop       = word_ready && (r_count != {CW{1'b0}});
  assign w_cnt_inc   = r_cnt + 10'd1;
  assign w_count_nxt = r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);

  assign word_valid  = (r_count != {CW{1'b0}});
  assign word_data   = r_mem[r_rd_ptr];
  assign done        = r_done;

  // Next-state and push decode; word0 is always the older word when both push.
  always_comb begin
    w_state_nxt  = r_state;
    w_colour_nxt = r_colour;
    w_cnt_nxt    = r_cnt;
    w_push0      = 1'b0;
    w_push1      = 1'b0;
    w_word0      = 16'd0;
    w_word1      = 16'd0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (pixel_last) begin
            w_push0 = 1'b1;
            w_word0 = {10'd1, pixel_colour};
          end else begin
            w_state_nxt  = S_RUN;
            w_cnt_nxt    = 10'd1;
            w_colour_nxt = pixel_colour;
          end
        end else if (finish && !w_full) begin
          w_push0     = 1'b1;
          w_word0     = STOP_WORD;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_acc) begin
          if ((pixel_colour == r_colour) && (r_cnt < MAX_RUN_W)) begin
            if (pixel_last) begin
              w_push0     = 1'b1;
              w_word0     = {w_cnt_inc, r_colour};
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_push0 = 1'b1;
            w_word0 = {r_cnt, r_colour};
            if (pixel_last) begin
              w_push1     = 1'b1;
              w_word1     = {10'd1, pixel_colour};
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt    = 10'd1;
              w_colour_nxt = pixel_colour;
            end
          end
        end else if (finish && !w_full) begin
          // Close the open run; the stop word follows from IDLE.
          w_push0     = 1'b1;
          w_word0     = {r_cnt, r_colour};
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Encoder state, open run and the registered done flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_colour <= 6'd0;
      r_cnt    <= 10'd0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_colour <= w_colour_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= (w_state_nxt == S_DONE) && (w_count_nxt == {CW{1'b0}});
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 16'd0;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push0) begin
        r_mem[r_wr_ptr] <= w_word0;
      end
      if (w_push1) begin
        r_mem[r_wr_ptr + AW'(1)] <= w_word1;
      end
      r_wr_ptr <= r_wr_ptr + AW'(w_push0) + AW'(w_push1);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= w_count_nxt;
    end
  end

endmodule
